// File: rtl/counter_updn_mod.sv
// rtl/counter_updn_mod.sv - parametrised up/down modulo counter with cascade carry and sticky overflow
module counter_updn_mod #(
  parameter int     WIDTH     = 8,
  parameter longint MODULUS   = 256,
  parameter longint RESET_VAL = 0,
  parameter bit     SAT_MODE  = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SCLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             CAI,
  input  logic             UP,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CAO,
  output logic             OVF
);

  // Largest legal modulus for this width; 64-bit so WIDTH=32 does not overflow.
  localparam longint MOD_MAX = longint'(1) << WIDTH;

  // Highest count value and the reset value, narrowed to the counter width.
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  // Reject impossible configurations while elaborating rather than misbehaving silently.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_updn_mod: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > MOD_MAX) begin : g_bad_modulus
    $error("counter_updn_mod: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("counter_updn_mod: RESET_VAL must be 0..MODULUS-1");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] d_clamped;
  logic             ovf_r;
  logic             ovf_nxt;
  logic             tc;
  logic             step;

  // Terminal count depends on direction: top of range going up, zero going down.
  always_comb begin
    tc = UP ? (q_r == TERM_UP) : (q_r == ZERO);
  end

  // A count step only happens when enabled, carried in, and not overridden by clear/load.
  always_comb begin
    step = EN & CAI & ~SCLR & ~LOAD;
  end

  // Value after one step: increment/decrement, or wrap/hold when sitting at terminal.
  always_comb begin
    q_step = q_r;
    if (UP) begin
      if (tc) begin
        q_step = SAT_MODE ? q_r : ZERO;
      end else begin
        q_step = q_r + 1'b1;
      end
    end else begin
      if (tc) begin
        q_step = SAT_MODE ? q_r : TERM_UP;
      end else begin
        q_step = q_r - 1'b1;
      end
    end
  end

  // Out-of-range load values are pinned to the top of the count range.
  always_comb begin
    d_clamped = (D > TERM_UP) ? TERM_UP : D;
  end

  // Next counter value with clear over load over step.
  always_comb begin
    q_nxt = q_r;
    if (SCLR) begin
      q_nxt = ZERO;
    end else if (LOAD) begin
      q_nxt = d_clamped;
    end else if (step) begin
      q_nxt = q_step;
    end
  end

  // Overflow is sticky; a new overflow event beats a simultaneous clear request.
  always_comb begin
    ovf_nxt = ovf_r;
    if (step && tc) begin
      ovf_nxt = 1'b1;
    end else if (OVF_CLR) begin
      ovf_nxt = 1'b0;
    end
  end

  // Counter and flag registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_r   <= RST_Q;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  // Carry-out is combinational so a chained upper stage steps on the same edge the lower one wraps.
  always_comb begin
    Q   = q_r;
    TC  = tc;
    CAO = EN & CAI & tc;
    OVF = ovf_r;
  end

endmodule

// File: tb/tb_counter_updn_mod.sv
// tb/tb_counter_updn_mod.sv - scoreboard bench for counter_updn_mod
module tb_counter_updn_mod;

  typedef struct packed {
    logic       sclr;
    logic       load;
    logic [7:0] d;
    logic       en;
    logic       cai;
    logic       up;
    logic       ovf_clr;
  } in_t;

  typedef struct {
    int          sel;
    string       name;
    logic [15:0] q;
    logic        ovf;
    logic        tc;
    logic        cao;
  } exp_t;

  logic CLK;
  logic RSTN;

  in_t ia, ib, ic, ik;
  logic [7:0] hi_d;

  logic [7:0] a_q;  logic a_tc, a_cao, a_ovf;
  logic [3:0] b_q;  logic b_tc, b_cao, b_ovf;
  logic [3:0] c_q;  logic c_tc, c_cao, c_ovf;
  logic [7:0] lo_q; logic lo_tc, lo_cao, lo_ovf;
  logic [7:0] hi_q; logic hi_tc, hi_cao, hi_ovf;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;

  counter_updn_mod #(.WIDTH(8), .MODULUS(256), .RESET_VAL(3), .SAT_MODE(1'b0)) u_a (
    .CLK(CLK), .RSTN(RSTN), .SCLR(ia.sclr), .LOAD(ia.load), .D(ia.d), .EN(ia.en),
    .CAI(ia.cai), .UP(ia.up), .OVF_CLR(ia.ovf_clr), .Q(a_q), .TC(a_tc), .CAO(a_cao), .OVF(a_ovf));

  counter_updn_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SAT_MODE(1'b0)) u_b (
    .CLK(CLK), .RSTN(RSTN), .SCLR(ib.sclr), .LOAD(ib.load), .D(ib.d[3:0]), .EN(ib.en),
    .CAI(ib.cai), .UP(ib.up), .OVF_CLR(ib.ovf_clr), .Q(b_q), .TC(b_tc), .CAO(b_cao), .OVF(b_ovf));

  counter_updn_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SAT_MODE(1'b1)) u_c (
    .CLK(CLK), .RSTN(RSTN), .SCLR(ic.sclr), .LOAD(ic.load), .D(ic.d[3:0]), .EN(ic.en),
    .CAI(ic.cai), .UP(ic.up), .OVF_CLR(ic.ovf_clr), .Q(c_q), .TC(c_tc), .CAO(c_cao), .OVF(c_ovf));

  counter_updn_mod #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0), .SAT_MODE(1'b0)) u_lo (
    .CLK(CLK), .RSTN(RSTN), .SCLR(ik.sclr), .LOAD(ik.load), .D(ik.d), .EN(ik.en),
    .CAI(ik.cai), .UP(ik.up), .OVF_CLR(ik.ovf_clr), .Q(lo_q), .TC(lo_tc), .CAO(lo_cao), .OVF(lo_ovf));

  counter_updn_mod #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0), .SAT_MODE(1'b0)) u_hi (
    .CLK(CLK), .RSTN(RSTN), .SCLR(ik.sclr), .LOAD(ik.load), .D(hi_d), .EN(ik.en),
    .CAI(lo_cao), .UP(ik.up), .OVF_CLR(ik.ovf_clr), .Q(hi_q), .TC(hi_tc), .CAO(hi_cao), .OVF(hi_ovf));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic exp_t mk(input int sel, input string name, input logic [15:0] q,
                              input logic ovf, input logic tc, input logic cao);
    exp_t e;
    e.sel = sel; e.name = name; e.q = q; e.ovf = ovf; e.tc = tc; e.cao = cao;
    return e;
  endfunction

  // Monitor: one expectation per falling edge, compared against the selected counter.
  always @(negedge CLK) begin
    exp_t e;
    logic [15:0] aq;
    logic ao, at, ac;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      popped++;
      case (e.sel)
        0:       begin aq = {8'h00, a_q};      ao = a_ovf;  at = a_tc;  ac = a_cao;  end
        1:       begin aq = {12'h000, b_q};    ao = b_ovf;  at = b_tc;  ac = b_cao;  end
        2:       begin aq = {12'h000, c_q};    ao = c_ovf;  at = c_tc;  ac = c_cao;  end
        default: begin aq = {hi_q, lo_q};      ao = hi_ovf; at = lo_tc; ac = lo_cao; end
      endcase
      checks++;
      if (aq !== e.q || ao !== e.ovf || at !== e.tc || ac !== e.cao) begin
        failures++;
        $display("FAIL %s: got q=%h ovf=%b tc=%b cao=%b, expected q=%h ovf=%b tc=%b cao=%b",
                 e.name, aq, ao, at, ac, e.q, e.ovf, e.tc, e.cao);
      end
    end
  end

  // Queue an expectation for the next falling edge and advance one cycle.
  task automatic cyc(input exp_t e);
    sb.push_back(e);
    pushed++;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    in_t idle;
    int  wait_cnt;
    idle = '{sclr: 1'b0, load: 1'b0, d: 8'h00, en: 1'b0, cai: 1'b1, up: 1'b1, ovf_clr: 1'b0};
    ia = idle; ib = idle; ic = idle; ik = idle; hi_d = 8'h00;
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RSTN = 1'b1;

    // Reset state of every counter
    cyc(mk(0, "rst_a",    16'h0003, 1'b0, 1'b0, 1'b0));
    cyc(mk(1, "rst_b",    16'h0000, 1'b0, 1'b0, 1'b0));
    cyc(mk(2, "rst_c",    16'h0000, 1'b0, 1'b0, 1'b0));
    cyc(mk(3, "rst_k",    16'h0000, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset mid-count, no clock edge before the sample
    ia.load = 1'b1; ia.d = 8'h5A;
    cyc(mk(0, "a_load5a", 16'h005A, 1'b0, 1'b0, 1'b0));
    ia.load = 1'b0;
    @(posedge CLK);
    #1 RSTN = 1'b0;
    sb.push_back(mk(0, "a_async_rst", 16'h0003, 1'b0, 1'b0, 1'b0));
    pushed++;
    @(negedge CLK);
    #1 RSTN = 1'b1;
    ia.en = 1'b1;
    cyc(mk(0, "a_step_after_rst", 16'h0004, 1'b0, 1'b0, 1'b0));
    ia.en = 1'b0;

    // Wrap up at MODULUS-1, load ignores EN
    ib.load = 1'b1; ib.d = 8'd9; ib.en = 1'b1;
    cyc(mk(1, "b_load9_en",   16'd9, 1'b0, 1'b1, 1'b1));
    ib.load = 1'b0;
    cyc(mk(1, "b_wrap_up",    16'd0, 1'b1, 1'b0, 1'b0));
    cyc(mk(1, "b_step",       16'd1, 1'b1, 1'b0, 1'b0));
    ib.en = 1'b0; ib.ovf_clr = 1'b1;
    cyc(mk(1, "b_ovf_clr",    16'd1, 1'b0, 1'b0, 1'b0));
    ib.ovf_clr = 1'b0;

    // Count down through zero, then flip direction mid-count
    ib.up = 1'b0; ib.en = 1'b1;
    cyc(mk(1, "b_down_to0",   16'd0, 1'b0, 1'b1, 1'b1));
    cyc(mk(1, "b_wrap_down",  16'd9, 1'b1, 1'b0, 1'b0));
    ib.up = 1'b1;
    cyc(mk(1, "b_dir_change", 16'd0, 1'b1, 1'b0, 1'b0));
    ib.en = 1'b0; ib.ovf_clr = 1'b1;
    cyc(mk(1, "b_clr2",       16'd0, 1'b0, 1'b0, 1'b0));
    ib.ovf_clr = 1'b0;

    // Priority and load clamp
    ib.load = 1'b1; ib.d = 8'd5;
    cyc(mk(1, "b_load5",      16'd5, 1'b0, 1'b0, 1'b0));
    ib.sclr = 1'b1; ib.d = 8'd7; ib.en = 1'b1;
    cyc(mk(1, "b_sclr_prio",  16'd0, 1'b0, 1'b0, 1'b0));
    ib.sclr = 1'b0; ib.d = 8'd12;
    cyc(mk(1, "b_load_clamp", 16'd9, 1'b0, 1'b1, 1'b1));

    // Overflow set beats clear; EN or CAI low holds at terminal
    ib.load = 1'b0; ib.ovf_clr = 1'b1;
    cyc(mk(1, "b_set_wins_clr",   16'd0, 1'b1, 1'b0, 1'b0));
    ib.ovf_clr = 1'b0; ib.load = 1'b1; ib.d = 8'd9; ib.en = 1'b0;
    cyc(mk(1, "b_en0_tc",         16'd9, 1'b1, 1'b1, 1'b0));
    ib.load = 1'b0;
    cyc(mk(1, "b_en0_hold",       16'd9, 1'b1, 1'b1, 1'b0));
    ib.en = 1'b1; ib.cai = 1'b0;
    cyc(mk(1, "b_cai0_hold",      16'd9, 1'b1, 1'b1, 1'b0));
    ib.sclr = 1'b1;
    cyc(mk(1, "b_sclr_keeps_ovf", 16'd0, 1'b1, 1'b0, 1'b0));
    ib = idle;

    // Saturating counter: hold at both ends, carry still asserted
    ic.up = 1'b0; ic.en = 1'b1;
    cyc(mk(2, "c_sat_down", 16'd0, 1'b1, 1'b1, 1'b1));
    ic.en = 1'b0; ic.ovf_clr = 1'b1;
    cyc(mk(2, "c_ovf_clr",  16'd0, 1'b0, 1'b1, 1'b0));
    ic.ovf_clr = 1'b0; ic.up = 1'b1; ic.load = 1'b1; ic.d = 8'd9;
    cyc(mk(2, "c_load9",    16'd9, 1'b0, 1'b1, 1'b0));
    ic.load = 1'b0; ic.en = 1'b1;
    cyc(mk(2, "c_sat_up",   16'd9, 1'b1, 1'b1, 1'b1));
    ic = idle;

    // Two-stage cascade: carry ripples combinationally into the upper stage
    ik.load = 1'b1; ik.d = 8'hFF; hi_d = 8'h00;
    cyc(mk(3, "k_load",      16'h00FF, 1'b0, 1'b1, 1'b0));
    ik.load = 1'b0; ik.en = 1'b1;
    cyc(mk(3, "k_carry",     16'h0100, 1'b0, 1'b0, 1'b0));
    cyc(mk(3, "k_step",      16'h0101, 1'b0, 1'b0, 1'b0));
    ik.cai = 1'b0;
    cyc(mk(3, "k_cai0_hold", 16'h0101, 1'b0, 1'b0, 1'b0));
    ik = idle;

    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(negedge CLK);
      wait_cnt++;
    end
    #1;
    checks++;
    if (sb.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL sb_drain: popped=%0d left=%0d, expected popped=%0d left=0",
               popped, sb.size(), pushed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
